// File: rtl/ibex_mem_port_arbiter.sv
// ibex_mem_port_arbiter
// Lets the Ibex instruction-fetch and load/store ports share one downstream
// memory port, which is all a single-port RAM in the simple system offers.
// - One requester is picked per cycle. An ungranted request locks that
//   choice until the memory grants it.
// - Each granted transaction's owner goes into an in-order ID FIFO, and the
//   FIFO head routes every response back to its owner.
// - Request, grant and response paths are combinational, so the arbiter adds
//   no latency or bubbles.
// Optional feature macro: IBEX_ARB_RR_EN
//   defined   -> round-robin on contention (rr_last tracks the last grant)
//   undefined -> fixed priority, the data side wins contention

module ibex_mem_port_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        resp_err_o
);

    // Occupancy must be able to hold the value MaxOutstanding itself.
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    // A single-entry FIFO still needs a one-bit pointer.
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    // ID encoding stored in the FIFO and the lock.
    localparam logic IdInstr = 1'b0;
    localparam logic IdData  = 1'b1;

    // Advance a FIFO pointer, wrapping modulo MaxOutstanding. The depth need
    // not be a power of two, so the wrap is explicit.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrLast) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [MaxOutstanding-1:0] fifo_r;
    logic [PtrW-1:0]           wr_ptr_r;
    logic [PtrW-1:0]           rd_ptr_r;
    logic [CntW-1:0]           cnt_r;
    logic                      lock_vld_r;
    logic                      lock_id_r;
    logic                      resp_err_r;
`ifdef IBEX_ARB_RR_EN
    logic                      rr_last_r;
`endif

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic sel_data_s;   // selected requester (IdInstr / IdData)
    logic any_req_s;
    logic room_s;       // FIFO can accept another outstanding transaction
    logic mem_req_s;
    logic grant_s;
    logic push_s;
    logic pop_s;
    logic spurious_s;
    logic head_id_s;

    assign any_req_s  = instr_req_i | data_req_i;
    assign room_s     = (cnt_r < CntMax);
    assign mem_req_s  = any_req_s & room_s;
    assign grant_s    = mem_gnt_i & mem_req_s;
    assign push_s     = grant_s;
    assign pop_s      = mem_rvalid_i & (cnt_r != '0);
    assign spurious_s = mem_rvalid_i & (cnt_r == '0);
    assign head_id_s  = fifo_r[rd_ptr_r];

    // Pick the requester that owns the memory port this cycle.
    always_comb begin
        sel_data_s = IdInstr;
        if (lock_vld_r) begin
            // An earlier ungranted request holds the port until it is granted.
            sel_data_s = lock_id_r;
        end else if (instr_req_i && !data_req_i) begin
            sel_data_s = IdInstr;
        end else if (data_req_i && !instr_req_i) begin
            sel_data_s = IdData;
        end else if (instr_req_i && data_req_i) begin
`ifdef IBEX_ARB_RR_EN
            // The side that was not granted last time goes first.
            sel_data_s = ~rr_last_r;
`else
            sel_data_s = IdData;
`endif
        end else begin
            // Idle: the instruction path shows on the memory port by default.
            sel_data_s = IdInstr;
        end
    end

    // Steer the selected requester onto the downstream port.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = 32'h0000_0000;
        if (sel_data_s == IdData) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            // Fetches are always full-word reads.
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0000_0000;
        end
    end

    // Return the grant to the selected side and the response to the FIFO head.
    always_comb begin
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        if (sel_data_s == IdData) begin
            data_gnt_o = grant_s;
        end else begin
            instr_gnt_o = grant_s;
        end
        if (pop_s) begin
            if (head_id_s == IdData) begin
                data_rvalid_o = 1'b1;
            end else begin
                instr_rvalid_o = 1'b1;
            end
        end else begin
            instr_rvalid_o = 1'b0;
            data_rvalid_o  = 1'b0;
        end
    end

    assign mem_req_o     = mem_req_s;
    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;
    assign resp_err_o    = resp_err_r;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Record the owner of each granted transaction at the write pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_r   <= '0;
            wr_ptr_r <= '0;
        end else if (push_s) begin
            fifo_r[wr_ptr_r] <= sel_data_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
        end
    end

    // Retire the head entry when its response arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_r <= '0;
        end else if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
    end

    // Occupancy count. A push and a pop in the same cycle cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Selection lock. An ungranted request freezes the choice so the memory
    // sees a stable address and data until it grants.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_vld_r <= 1'b0;
            lock_id_r  <= IdInstr;
        end else if (mem_req_s && !mem_gnt_i) begin
            lock_vld_r <= 1'b1;
            lock_id_r  <= sel_data_s;
        end else if (mem_gnt_i) begin
            lock_vld_r <= 1'b0;
        end
    end

`ifdef IBEX_ARB_RR_EN
    // Remember the last granted side for round-robin. Resetting to data
    // lets the instruction side win first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last_r <= IdData;
        end else if (grant_s) begin
            rr_last_r <= sel_data_s;
        end
    end
`endif

    // Sticky flag: a response arrived with nothing outstanding. Only reset
    // clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_err_r <= 1'b0;
        end else if (spurious_s) begin
            resp_err_r <= 1'b1;
        end
    end

endmodule

// File: doc/ibex_mem_port_arbiter.md
# ibex_mem_port_arbiter

Shares a single downstream memory port between the Ibex instruction-fetch and load/store interfaces in the simple system, so one single-port RAM can serve both. Each requester uses the Ibex req/gnt/rvalid protocol. The arbiter selects one requester per cycle and locks that selection until the downstream port grants. It records the owner of each granted transaction in an in-order ID FIFO and routes every response back to its owner.

## Interface
Parameters:
- MaxOutstanding, 2: maximum granted-but-unanswered transactions (1..4); sets the ID FIFO depth.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- instr_req_i  input  1  instruction-side request.
- instr_gnt_o  output  1  instruction-side grant.
- instr_rvalid_o  output  1  instruction-side response valid.
- instr_addr_i  input  32  instruction address.
- instr_rdata_o  output  32  instruction read data.
- data_req_i  input  1  data-side request.
- data_gnt_o  output  1  data-side grant.
- data_rvalid_o  output  1  data-side response valid.
- data_we_i  input  1  data write enable.
- data_be_i  input  4  data byte enables.
- data_addr_i  input  32  data address.
- data_wdata_i  input  32  data write data.
- data_rdata_o  output  32  data read data.
- mem_req_o, mem_we_o  output  1  downstream request and write enable.
- mem_be_o  output  4  downstream byte enables.
- mem_addr_o, mem_wdata_o  output  32  downstream address and write data.
- mem_gnt_i, mem_rvalid_i  input  1  downstream grant and response valid.
- mem_rdata_i  input  32  downstream read data.
- resp_err_o  output  1  sticky flag: a response arrived while no transaction was outstanding.

## Operation
**Registered state**
- ID FIFO: MaxOutstanding entries, 1 bit each (0 = instr, 1 = data).
- cnt: occupancy, width $clog2(MaxOutstanding+1).
- lock_vld, lock_id: selection lock.
- rr_last: last granted requester.
- resp_err: sticky error flag.

**Selection**
- When lock_vld is set, the selected requester is lock_id.
- Otherwise, with only one requester asserting req, that requester is selected.
- Otherwise, with both asserting, the winner is set by the configuration (see Configuration).

**Forwarding**
- The selected requester's signals drive mem_*.
- Instruction transactions drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- mem_req_o = (instr_req_i | data_req_i) & (cnt < MaxOutstanding).

**Grant**
- The selected requester's gnt_o = mem_gnt_i & mem_req_o.
- The unselected requester's gnt_o is 0.
- A grant pushes the selected requester's ID into the FIFO.

**Lock**
- Set when mem_req_o=1 and mem_gnt_i=0; lock_id is then the selected requester.
- Cleared on the cycle in which mem_gnt_i=1.
- While the lock is set, the downstream address and data stay stable until the grant.

**Response**
- When mem_rvalid_i=1 and cnt>0, the response goes to the FIFO head: that requester's rvalid_o=1, and the head is popped.
- rdata_o of both requesters is driven by mem_rdata_i at all times.
- When mem_rvalid_i=1 and cnt==0, no rvalid_o is asserted and resp_err is set. Only reset clears resp_err.

**Boundary conditions**
- Push and pop in the same cycle: cnt is unchanged and FIFO order is preserved.
- FIFO full (cnt==MaxOutstanding): mem_req_o=0, even if a pop occurs in the same cycle.
- FIFO pointers wrap modulo MaxOutstanding.
- Reset mid-transaction: the FIFO, cnt, lock and rr_last are discarded. Later downstream responses with cnt==0 set resp_err_o.

## Timing
- Request, address and grant paths are combinational: zero added latency from requester to the memory port.
- Response routing is combinational from mem_rvalid_i: same-cycle delivery.
- The arbiter adds no bubble. Back-to-back grants are possible every cycle while cnt < MaxOutstanding.

**Reset**
- Values asserted during rst_i: cnt=0, FIFO pointers=0, lock_vld=0, lock_id=0, rr_last=1 (so the instruction side wins first), resp_err=0.
- Outputs with no requests pending: mem_req_o=0, both gnt_o=0, both rvalid_o=0, resp_err_o=0.
- mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o show the instruction-side default path.

**Lock timing**
- The lock takes effect from the cycle after an ungranted request.
- A requester that deasserts req while locked violates the protocol. The lock holds regardless.

## Configuration
- IBEX_ARB_RR_EN defined: round-robin arbitration.
  - On contention, the winner is the requester not equal to rr_last.
  - rr_last updates on every grant.
- IBEX_ARB_RR_EN undefined: fixed priority.
  - The data side always wins contention.
  - rr_last is unused and may be optimised away.

## Test plan
- Single instruction fetch: instr_req_i=1, addr 0x80, mem_gnt_i=1 in the same cycle, mem_rvalid_i=1 the next cycle with rdata 0xDEADBEEF → instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF in cycle 1; data_rvalid_o=0 throughout.
- Contention:
  - Setup: both req asserted for 4 cycles, mem_gnt_i=1 on every cycle.
  - With IBEX_ARB_RR_EN defined, the grants must go instr, data, instr, data.
  - With it undefined, the grants must go data ×4.
- Lock: data_req_i=1 at addr 0x100 with mem_gnt_i=0 for 3 cycles, then instr_req_i also raised → mem_addr_o stays 0x100 and instr_gnt_o=0 until mem_gnt_i=1.
- Outstanding limit:
  - Setup: MaxOutstanding=2, instr_req_i=1, mem_gnt_i=1, no responses.
  - Two grants occur, then mem_req_o=0.
  - When one rvalid arrives, mem_req_o=1 again from the following cycle.
- Ordering: grant instr then data (cnt=2), then two responses 0x11 and 0x22 → instr_rvalid_o receives 0x11 and data_rvalid_o then receives 0x22.
- Spurious response: mem_rvalid_i=1 with cnt=0 → no rvalid_o is asserted, and resp_err_o=1 from the next cycle until rst_i is asserted.
